// File: rtl/mc_fifo_arbiter_pkg.sv
// Shared widths, defaults and response-FSM state encoding for mc_fifo_arbiter.
package mc_fifo_arbiter_pkg;

    localparam int DEF_NUM_MASTERS        = 4;
    localparam int DEF_ID_WIDTH           = 2;
    localparam int DEF_DATA_LINE_WIDTH    = 64;
    localparam int DEF_CONTROL_LINE_WIDTH = 6;
    localparam int DEF_MAX_OUTSTANDING    = 4;
    localparam int GRANT_CNT_WIDTH        = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        CAP  = 2'd2,
        DLV  = 2'd3
    } resp_state_t;

endpackage

// File: rtl/mc_fifo_arbiter_rr_arbiter.sv
// Round-robin arbiter: first requester at or above ptr (with wrap) wins.
// Latency: combinational. Backpressure: none; caller masks req to stall.
// Pointer ownership stays with the caller so it can decide when to advance.
module rr_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int ID_WIDTH    = 2
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [ID_WIDTH-1:0]    ptr,
    output logic [NUM_MASTERS-1:0] gnt,
    output logic                   gnt_vld,
    output logic [ID_WIDTH-1:0]    gnt_idx
);

    logic [ID_WIDTH-1:0] cand;

    // NUM_MASTERS == 2**ID_WIDTH, so the ID_WIDTH-bit add wraps naturally.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            cand = ptr + ID_WIDTH'(i);
            if (!gnt_vld && req[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    assign gnt = gnt_vld ? (NUM_MASTERS'(1) << gnt_idx) : '0;

endmodule

// File: rtl/mc_fifo_arbiter.sv
// Shares one send-request / receive-response FIFO pair between NUM_MASTERS requesters.
// Latency: request grant combinational; response delivered 3 cycles after FIFO non-empty.
// Backpressure: grants stop on FIFO full or per-master outstanding limit; DLV holds until
// the owning master is ready. Optional grant counters under MC_FIFO_ARB_STATS_EN.
module mc_fifo_arbiter
    import mc_fifo_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS        = DEF_NUM_MASTERS,
    parameter int ID_WIDTH           = DEF_ID_WIDTH,
    parameter int DATA_LINE_WIDTH    = DEF_DATA_LINE_WIDTH,
    parameter int CONTROL_LINE_WIDTH = DEF_CONTROL_LINE_WIDTH,
    parameter int MAX_OUTSTANDING    = DEF_MAX_OUTSTANDING,
    localparam int W                 = DATA_LINE_WIDTH + CONTROL_LINE_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_MASTERS-1:0]   i_req_valid,
    input  logic [NUM_MASTERS*W-1:0] i_req_bits,
    output logic [NUM_MASTERS-1:0]   o_req_ready,
    output logic                     o_sreq_wen,
    output logic [W-1:0]             o_sreq_bits,
    input  logic                     i_sreq_fifo_full,
    output logic                     o_rresp_ren,
    input  logic [W-1:0]             i_rresp_bits,
    input  logic                     i_rresp_fifo_empty,
    output logic [NUM_MASTERS-1:0]   o_resp_valid,
    output logic [W-1:0]             o_resp_bits,
    input  logic [NUM_MASTERS-1:0]   i_resp_ready
`ifdef MC_FIFO_ARB_STATS_EN
    ,
    output logic [NUM_MASTERS*GRANT_CNT_WIDTH-1:0] o_grant_cnt
`endif
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [ID_WIDTH-1:0]    rr_ptr_q;
    logic [CNT_W-1:0]       out_cnt_q [NUM_MASTERS];
    logic [NUM_MASTERS-1:0] eligible;
    logic [NUM_MASTERS-1:0] gnt;
    logic                   gnt_vld;
    logic [ID_WIDTH-1:0]    gnt_idx;
    logic [W-1:0]           sreq_word;

    resp_state_t            state_q, state_d;
    logic [W-1:0]           hold_q;
    logic [ID_WIDTH-1:0]    resp_id;
    logic [NUM_MASTERS-1:0] resp_hs;

    // Reset gating keeps the combinational grant path quiet while rst_n is low.
    always_comb begin
        eligible = '0;
        for (int m = 0; m < NUM_MASTERS; m++) begin
            eligible[m] = i_req_valid[m] && (out_cnt_q[m] < CNT_W'(MAX_OUTSTANDING));
        end
        if (i_sreq_fifo_full || !rst_n) begin
            eligible = '0;
        end
    end

    rr_arbiter #(
        .NUM_MASTERS (NUM_MASTERS),
        .ID_WIDTH    (ID_WIDTH)
    ) u_rr_arbiter (
        .req     (eligible),
        .ptr     (rr_ptr_q),
        .gnt     (gnt),
        .gnt_vld (gnt_vld),
        .gnt_idx (gnt_idx)
    );

    always_comb begin
        sreq_word = i_req_bits[gnt_idx*W +: W];
        sreq_word[DATA_LINE_WIDTH +: ID_WIDTH] = gnt_idx;
    end

    assign o_req_ready = gnt;
    assign o_sreq_wen  = gnt_vld;
    assign o_sreq_bits = sreq_word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
        end else if (gnt_vld) begin
            rr_ptr_q <= gnt_idx + ID_WIDTH'(1);
        end
    end

    assign resp_id      = hold_q[DATA_LINE_WIDTH +: ID_WIDTH];
    assign o_rresp_ren  = (state_q == RD);
    assign o_resp_valid = (state_q == DLV) ? (NUM_MASTERS'(1) << resp_id) : '0;
    assign o_resp_bits  = hold_q;
    assign resp_hs      = o_resp_valid & i_resp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!i_rresp_fifo_empty) state_d = RD;
            RD:      state_d = CAP;
            CAP:     state_d = DLV;
            DLV:     if (i_resp_ready[resp_id]) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FIFO read data is valid the cycle after the read strobe, i.e. in CAP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
        end else if (state_q == CAP) begin
            hold_q <= i_rresp_bits;
        end
    end

    // Responses to an idle master still deliver; the counter just floors at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int m = 0; m < NUM_MASTERS; m++) begin
                out_cnt_q[m] <= '0;
            end
        end else begin
            for (int m = 0; m < NUM_MASTERS; m++) begin
                if (gnt[m] && !resp_hs[m]) begin
                    out_cnt_q[m] <= out_cnt_q[m] + CNT_W'(1);
                end else if (!gnt[m] && resp_hs[m] && (out_cnt_q[m] != '0)) begin
                    out_cnt_q[m] <= out_cnt_q[m] - CNT_W'(1);
                end
            end
        end
    end

`ifdef MC_FIFO_ARB_STATS_EN
    logic [GRANT_CNT_WIDTH-1:0] grant_cnt_q [NUM_MASTERS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int m = 0; m < NUM_MASTERS; m++) begin
                grant_cnt_q[m] <= '0;
            end
        end else begin
            for (int m = 0; m < NUM_MASTERS; m++) begin
                if (gnt[m] && (grant_cnt_q[m] != '1)) begin
                    grant_cnt_q[m] <= grant_cnt_q[m] + GRANT_CNT_WIDTH'(1);
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_grant_cnt
        assign o_grant_cnt[g*GRANT_CNT_WIDTH +: GRANT_CNT_WIDTH] = grant_cnt_q[g];
    end
`endif

endmodule

// File: tb/tb_mc_fifo_arbiter.sv
// Directed bench for mc_fifo_arbiter: grants, limits, full flag, response FSM, reset.
module tb_mc_fifo_arbiter;
    import mc_fifo_arbiter_pkg::*;

    localparam int NM  = 4;
    localparam int DLW = 64;
    localparam int W   = 70;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NM-1:0]   i_req_valid;
    logic [NM*W-1:0] i_req_bits;
    logic [NM-1:0]   o_req_ready;
    logic            o_sreq_wen;
    logic [W-1:0]    o_sreq_bits;
    logic            i_sreq_fifo_full;
    logic            o_rresp_ren;
    logic [W-1:0]    i_rresp_bits;
    logic            i_rresp_fifo_empty;
    logic [NM-1:0]   o_resp_valid;
    logic [W-1:0]    o_resp_bits;
    logic [NM-1:0]   i_resp_ready;
`ifdef MC_FIFO_ARB_STATS_EN
    logic [NM*16-1:0] o_grant_cnt;
`endif

    int checks = 0;
    int errors = 0;

    logic [NM-1:0] exp_rdy;
    logic [W-1:0]  exp_word;

    always #5 clk = ~clk;

    mc_fifo_arbiter dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .i_req_valid        (i_req_valid),
        .i_req_bits         (i_req_bits),
        .o_req_ready        (o_req_ready),
        .o_sreq_wen         (o_sreq_wen),
        .o_sreq_bits        (o_sreq_bits),
        .i_sreq_fifo_full   (i_sreq_fifo_full),
        .o_rresp_ren        (o_rresp_ren),
        .i_rresp_bits       (i_rresp_bits),
        .i_rresp_fifo_empty (i_rresp_fifo_empty),
        .o_resp_valid       (o_resp_valid),
        .o_resp_bits        (o_resp_bits),
        .i_resp_ready       (i_resp_ready)
`ifdef MC_FIFO_ARB_STATS_EN
        ,
        .o_grant_cnt        (o_grant_cnt)
`endif
    );

    function automatic logic [W-1:0] exp_sreq(input int m);
        logic [1:0] id;
        id = m[1:0];
        return {4'b1111, id, 64'(64'hA0 + m)};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_n              = 1'b0;
        i_req_valid        = '0;
        i_sreq_fifo_full   = 1'b0;
        i_rresp_fifo_empty = 1'b1;
        i_resp_ready       = '0;
        i_rresp_bits       = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Pushes one response word through IDLE->RD->CAP, leaving the FSM in DLV.
    task automatic load_resp(input logic [W-1:0] word);
        i_rresp_bits       = word;
        i_rresp_fifo_empty = 1'b0;
        cyc();
        i_rresp_fifo_empty = 1'b1;
        cyc();
        cyc();
    endtask

    task automatic test_reset();
        rst_n              = 1'b0;
        i_req_valid        = 4'hF;
        i_sreq_fifo_full   = 1'b0;
        i_rresp_fifo_empty = 1'b0;
        i_resp_ready       = 4'hF;
        #2;
        checks++; if (o_req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got %b exp 0000", o_req_ready); end
        checks++; if (o_sreq_wen !== 1'b0) begin errors++; $display("FAIL reset_sreq_wen got %b exp 0", o_sreq_wen); end
        checks++; if (o_rresp_ren !== 1'b0) begin errors++; $display("FAIL reset_rresp_ren got %b exp 0", o_rresp_ren); end
        checks++; if (o_resp_valid !== 4'b0000) begin errors++; $display("FAIL reset_resp_valid got %b exp 0000", o_resp_valid); end
        checks++; if (o_resp_bits !== '0) begin errors++; $display("FAIL reset_resp_bits got %h exp 0", o_resp_bits); end
        apply_reset();
    endtask

    task automatic test_round_robin();
        apply_reset();
        i_req_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            smp();
            exp_rdy  = 4'b0001 << (k % 4);
            exp_word = exp_sreq(k % 4);
            checks++; if (o_req_ready !== exp_rdy) begin errors++; $display("FAIL rr_ready k=%0d got %b exp %b", k, o_req_ready, exp_rdy); end
            checks++; if (o_sreq_wen !== 1'b1) begin errors++; $display("FAIL rr_wen k=%0d got %b exp 1", k, o_sreq_wen); end
            checks++; if (o_sreq_bits !== exp_word) begin errors++; $display("FAIL rr_bits k=%0d got %h exp %h", k, o_sreq_bits, exp_word); end
            cyc();
        end
        i_req_valid = '0;
`ifdef MC_FIFO_ARB_STATS_EN
        smp();
        checks++; if (o_grant_cnt[15:0] !== 16'd2) begin errors++; $display("FAIL stats_m0 got %0d exp 2", o_grant_cnt[15:0]); end
        checks++; if (o_grant_cnt[31:16] !== 16'd1) begin errors++; $display("FAIL stats_m1 got %0d exp 1", o_grant_cnt[31:16]); end
        cyc();
`endif
    endtask

    task automatic test_max_outstanding();
        apply_reset();
        i_req_valid = 4'b0100;
        for (int k = 0; k < 5; k++) begin
            smp();
            exp_rdy = (k < 4) ? 4'b0100 : 4'b0000;
            checks++; if (o_req_ready !== exp_rdy) begin errors++; $display("FAIL maxout_ready k=%0d got %b exp %b", k, o_req_ready, exp_rdy); end
            checks++; if (o_sreq_wen !== (k < 4)) begin errors++; $display("FAIL maxout_wen k=%0d got %b exp %b", k, o_sreq_wen, (k < 4)); end
            cyc();
        end
        i_req_valid = '0;
    endtask

    task automatic test_fifo_full();
        apply_reset();
        i_req_valid = 4'b0001;
        smp();
        checks++; if (o_req_ready !== 4'b0001) begin errors++; $display("FAIL full_pre got %b exp 0001", o_req_ready); end
        cyc();
        i_req_valid      = 4'hF;
        i_sreq_fifo_full = 1'b1;
        for (int k = 0; k < 2; k++) begin
            smp();
            checks++; if (o_sreq_wen !== 1'b0) begin errors++; $display("FAIL full_wen k=%0d got %b exp 0", k, o_sreq_wen); end
            checks++; if (o_req_ready !== 4'b0000) begin errors++; $display("FAIL full_ready k=%0d got %b exp 0000", k, o_req_ready); end
            cyc();
        end
        i_sreq_fifo_full = 1'b0;
        smp();
        exp_word = exp_sreq(1);
        checks++; if (o_req_ready !== 4'b0010) begin errors++; $display("FAIL full_release_ready got %b exp 0010", o_req_ready); end
        checks++; if (o_sreq_bits !== exp_word) begin errors++; $display("FAIL full_release_bits got %h exp %h", o_sreq_bits, exp_word); end
        cyc();
        i_req_valid = '0;
    endtask

    task automatic test_response();
        apply_reset();
        exp_word           = {4'b0000, 2'd3, 64'h46};
        i_rresp_bits       = exp_word;
        i_rresp_fifo_empty = 1'b0;
        smp();
        checks++; if (o_rresp_ren !== 1'b0) begin errors++; $display("FAIL resp_c0_ren got %b exp 0", o_rresp_ren); end
        cyc();
        i_rresp_fifo_empty = 1'b1;
        smp();
        checks++; if (o_rresp_ren !== 1'b1) begin errors++; $display("FAIL resp_c1_ren got %b exp 1", o_rresp_ren); end
        cyc();
        smp();
        checks++; if (o_rresp_ren !== 1'b0) begin errors++; $display("FAIL resp_c2_ren got %b exp 0", o_rresp_ren); end
        checks++; if (o_resp_valid !== 4'b0000) begin errors++; $display("FAIL resp_c2_valid got %b exp 0000", o_resp_valid); end
        cyc();
        smp();
        checks++; if (o_resp_valid !== 4'b1000) begin errors++; $display("FAIL resp_c3_valid got %b exp 1000", o_resp_valid); end
        checks++; if (o_resp_bits !== exp_word) begin errors++; $display("FAIL resp_c3_bits got %h exp %h", o_resp_bits, exp_word); end
        cyc();
        i_resp_ready = 4'b0111;
        smp();
        checks++; if (o_resp_valid !== 4'b1000) begin errors++; $display("FAIL resp_hold_valid got %b exp 1000", o_resp_valid); end
        cyc();
        i_resp_ready = 4'b1000;
        smp();
        checks++; if (o_resp_valid !== 4'b1000) begin errors++; $display("FAIL resp_accept_valid got %b exp 1000", o_resp_valid); end
        cyc();
        i_resp_ready = '0;
        smp();
        checks++; if (o_resp_valid !== 4'b0000) begin errors++; $display("FAIL resp_done_valid got %b exp 0000", o_resp_valid); end
        checks++; if (o_rresp_ren !== 1'b0) begin errors++; $display("FAIL resp_done_ren got %b exp 0", o_rresp_ren); end
        cyc();
    endtask

    task automatic test_same_cycle();
        apply_reset();
        i_req_valid = 4'b0010;
        smp();
        checks++; if (o_req_ready !== 4'b0010) begin errors++; $display("FAIL same_first_grant got %b exp 0010", o_req_ready); end
        cyc();
        i_req_valid = '0;
        checks++; if (dut.out_cnt_q[1] !== 3'd1) begin errors++; $display("FAIL same_cnt_before got %0d exp 1", dut.out_cnt_q[1]); end
        load_resp({4'b0000, 2'd1, 64'h11});
        i_req_valid  = 4'b0010;
        i_resp_ready = 4'b0010;
        smp();
        checks++; if (o_resp_valid !== 4'b0010) begin errors++; $display("FAIL same_resp_valid got %b exp 0010", o_resp_valid); end
        checks++; if (o_req_ready !== 4'b0010) begin errors++; $display("FAIL same_req_ready got %b exp 0010", o_req_ready); end
        cyc();
        i_req_valid  = '0;
        i_resp_ready = '0;
        smp();
        checks++; if (dut.out_cnt_q[1] !== 3'd1) begin errors++; $display("FAIL same_cnt_after got %0d exp 1", dut.out_cnt_q[1]); end
        checks++; if (o_resp_valid !== 4'b0000) begin errors++; $display("FAIL same_resp_done got %b exp 0000", o_resp_valid); end
        cyc();
    endtask

    task automatic test_underflow();
        apply_reset();
        exp_word = {4'b0000, 2'd0, 64'h22};
        load_resp(exp_word);
        i_resp_ready = 4'b0001;
        smp();
        checks++; if (o_resp_valid !== 4'b0001) begin errors++; $display("FAIL uflow_valid got %b exp 0001", o_resp_valid); end
        checks++; if (o_resp_bits !== exp_word) begin errors++; $display("FAIL uflow_bits got %h exp %h", o_resp_bits, exp_word); end
        cyc();
        i_resp_ready = '0;
        smp();
        checks++; if (dut.out_cnt_q[0] !== 3'd0) begin errors++; $display("FAIL uflow_cnt got %0d exp 0", dut.out_cnt_q[0]); end
        cyc();
    endtask

    task automatic test_reset_mid_dlv();
        apply_reset();
        load_resp({4'b0000, 2'd2, 64'h33});
        smp();
        checks++; if (o_resp_valid !== 4'b0100) begin errors++; $display("FAIL rstdlv_pre got %b exp 0100", o_resp_valid); end
        rst_n       = 1'b0;
        i_req_valid = 4'hF;
        #1;
        checks++; if (o_resp_valid !== 4'b0000) begin errors++; $display("FAIL rstdlv_valid got %b exp 0000", o_resp_valid); end
        checks++; if (o_req_ready !== 4'b0000) begin errors++; $display("FAIL rstdlv_ready got %b exp 0000", o_req_ready); end
        checks++; if (o_sreq_wen !== 1'b0) begin errors++; $display("FAIL rstdlv_wen got %b exp 0", o_sreq_wen); end
        checks++; if (o_resp_bits !== '0) begin errors++; $display("FAIL rstdlv_bits got %h exp 0", o_resp_bits); end
        @(posedge clk);
        #1;
        rst_n       = 1'b1;
        i_req_valid = '0;
        for (int k = 0; k < 2; k++) begin
            smp();
            checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL rstdlv_state k=%0d got %0d exp %0d", k, dut.state_q, IDLE); end
            checks++; if (o_rresp_ren !== 1'b0) begin errors++; $display("FAIL rstdlv_ren k=%0d got %b exp 0", k, o_rresp_ren); end
            cyc();
        end
    endtask

    initial begin
        for (int m = 0; m < NM; m++) begin
            i_req_bits[m*W +: W] = {6'b111111, 64'(64'hA0 + m)};
        end
        i_req_valid        = '0;
        i_sreq_fifo_full   = 1'b0;
        i_rresp_fifo_empty = 1'b1;
        i_rresp_bits       = '0;
        i_resp_ready       = '0;
        rst_n              = 1'b0;
        test_reset();
        test_round_robin();
        test_max_outstanding();
        test_fifo_full();
        test_response();
        test_same_cycle();
        test_underflow();
        test_reset_mid_dlv();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
